// File: rtl/mrr_tx_packet_modulator.sv
// OOK baseband packet framer: header chips, payload bits, then a zero recharge gap,
// streamed as {I,Q} samples on an AXI-stream master with a single tlast per packet.
module mrr_tx_packet_modulator #(
  parameter int          HEADER_LEN     = 16,
  parameter logic [31:0] HEADER_PATTERN = 32'hB38F,
  parameter int          SPB_WIDTH      = 16,
  parameter logic [15:0] AMPLITUDE      = 16'h4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [31:0]          tx_word,
  input  logic [7:0]           num_payload_bits,
  input  logic [SPB_WIDTH-1:0] samps_per_bit,
  input  logic [14:0]          recharge_len,
  input  logic                 tx_disable,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          packet_count,
  output logic [31:0]          o_tdata,
  output logic                 o_tvalid,
  output logic                 o_tlast,
  input  logic                 o_tready
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, RECHARGE} state_t;

  localparam logic [SPB_WIDTH-1:0] SPB_ONE  = SPB_WIDTH'(1);
  localparam logic [5:0]           HDR_LAST = 6'(HEADER_LEN - 1);
  localparam logic [4:0]           HDR_TOP  = 5'(HEADER_LEN - 1);

  state_t               state, state_nxt;

  // Packet parameters captured at accept; the live inputs are ignored afterwards.
  logic [31:0]          word_q;
  logic [5:0]           nbits_q;
  logic [SPB_WIDTH-1:0] spb_q;
  logic [14:0]          rech_q;

  // Position of the sample currently presented on the stream.
  logic [SPB_WIDTH-1:0] samp_cnt, samp_nxt;
  logic [5:0]           chip_cnt, chip_nxt;
  logic [14:0]          rech_cnt, rech_nxt;

  logic                 accept, fire, finish;
  logic                 samp_end, hdr_end, pay_end, rch_end;
  logic [4:0]           hdr_idx, pay_idx;
  logic                 chip_bit;
  logic [5:0]           nbits_in;
  logic [SPB_WIDTH-1:0] spb_in;

  assign accept   = (state == IDLE) && tx_start && !tx_disable;
  assign fire     = o_tvalid && o_tready;

  assign nbits_in = (num_payload_bits > 8'd32) ? 6'd32 : num_payload_bits[5:0];
  assign spb_in   = (samps_per_bit == '0) ? SPB_ONE : samps_per_bit;

  assign samp_end = (samp_cnt == spb_q - SPB_ONE);
  assign hdr_end  = (chip_cnt == HDR_LAST);
  assign pay_end  = (chip_cnt == nbits_q - 6'd1);
  assign rch_end  = (rech_cnt == rech_q - 15'd1);

  // 5-bit wrap makes nbits_q=32 index word_q[31] on the first payload bit.
  assign hdr_idx  = HDR_TOP - chip_cnt[4:0];
  assign pay_idx  = nbits_q[4:0] - 5'd1 - chip_cnt[4:0];

  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    chip_nxt  = chip_cnt;
    rech_nxt  = rech_cnt;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HEADER;
          samp_nxt  = '0;
          chip_nxt  = '0;
          rech_nxt  = '0;
        end
      end
      HEADER: begin
        if (fire) begin
          if (!samp_end) begin
            samp_nxt = samp_cnt + SPB_ONE;
          end else begin
            samp_nxt = '0;
            if (!hdr_end) begin
              chip_nxt = chip_cnt + 6'd1;
            end else begin
              chip_nxt = '0;
              if (nbits_q != 6'd0) begin
                state_nxt = PAYLOAD;
              end else if (rech_q != 15'd0) begin
                state_nxt = RECHARGE;
              end else begin
                state_nxt = IDLE;
                finish    = 1'b1;
              end
            end
          end
        end
      end
      PAYLOAD: begin
        if (fire) begin
          if (!samp_end) begin
            samp_nxt = samp_cnt + SPB_ONE;
          end else begin
            samp_nxt = '0;
            if (!pay_end) begin
              chip_nxt = chip_cnt + 6'd1;
            end else if (rech_q != 15'd0) begin
              state_nxt = RECHARGE;
            end else begin
              state_nxt = IDLE;
              finish    = 1'b1;
            end
          end
        end
      end
      RECHARGE: begin
        if (fire) begin
          if (!rch_end) begin
            rech_nxt = rech_cnt + 15'd1;
          end else begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      samp_cnt     <= '0;
      chip_cnt     <= '0;
      rech_cnt     <= '0;
      word_q       <= '0;
      nbits_q      <= '0;
      spb_q        <= SPB_ONE;
      rech_q       <= '0;
      done         <= 1'b0;
      packet_count <= '0;
    end else begin
      state    <= state_nxt;
      samp_cnt <= samp_nxt;
      chip_cnt <= chip_nxt;
      rech_cnt <= rech_nxt;
      done     <= finish;
      if (finish) packet_count <= packet_count + 16'd1;
      if (accept) begin
        word_q  <= tx_word;
        nbits_q <= nbits_in;
        spb_q   <= spb_in;
        rech_q  <= recharge_len;
      end
    end
  end

  // Outputs decode from registered position only, so they hold still while stalled.
  always_comb begin
    chip_bit = 1'b0;
    case (state)
      HEADER:  chip_bit = HEADER_PATTERN[hdr_idx];
      PAYLOAD: chip_bit = word_q[pay_idx];
      default: chip_bit = 1'b0;
    endcase
  end

  assign o_tdata  = chip_bit ? {AMPLITUDE, 16'h0000} : 32'h0;
  assign o_tvalid = (state != IDLE);
  assign busy     = (state != IDLE);
  assign o_tlast  = ((state == HEADER)   && samp_end && hdr_end && (nbits_q == 6'd0) && (rech_q == 15'd0)) ||
                    ((state == PAYLOAD)  && samp_end && pay_end && (rech_q == 15'd0)) ||
                    ((state == RECHARGE) && rch_end);

endmodule

// File: tb/tb_mrr_tx_packet_modulator.sv
// Scoreboard bench: stimulus pushes expected samples, a negedge monitor pops on each handshake.
module tb_mrr_tx_packet_modulator;

  logic        clk = 1'b0;
  logic        rst, tx_start, tx_disable, o_tready;
  logic [31:0] tx_word;
  logic [7:0]  num_payload_bits;
  logic [15:0] samps_per_bit;
  logic [14:0] recharge_len;
  logic        busy, done, o_tvalid, o_tlast;
  logic [15:0] packet_count;
  logic [31:0] o_tdata;

  mrr_tx_packet_modulator dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_word(tx_word),
    .num_payload_bits(num_payload_bits), .samps_per_bit(samps_per_bit),
    .recharge_len(recharge_len), .tx_disable(tx_disable), .busy(busy), .done(done),
    .packet_count(packet_count), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
    .o_tlast(o_tlast), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] data; logic last;} exp_t;
  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  int          exp_pkts = 0, cur_len = 0, last_len = 0;
  logic        expect_done = 1'b0, rand_ready = 1'b0;
  logic [31:0] got [0:255];
  logic [15:0] hp = 16'hB38F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input logic [31:0] word, input int nb, input int spb, input int rech);
    int n, s;
    logic b;
    exp_t e;
    n = (nb > 32) ? 32 : nb;
    s = (spb == 0) ? 1 : spb;
    for (int c = 0; c < 16 + n; c++) begin
      b = (c < 16) ? hp[15 - c] : word[n - 1 - (c - 16)];
      for (int k = 0; k < s; k++) begin
        e.data = b ? 32'h4000_0000 : 32'h0;
        e.last = 1'b0;
        exp_q.push_back(e);
      end
    end
    for (int r = 0; r < rech; r++) begin
      e.data = 32'h0;
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    exp_q[exp_q.size() - 1].last = 1'b1;
  endtask

  // Monitor: all sampling on negedge, well away from the active edge.
  initial begin
    logic        prev_stall, prev_last;
    logic [31:0] prev_data;
    exp_t        e;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pkts = 0; expect_done = 1'b0; cur_len = 0; prev_stall = 1'b0;
      end else begin
        chk("done_pulse", 32'(done), 32'(expect_done));
        if (expect_done) begin
          chk("packet_count", 32'(packet_count), 32'(exp_pkts + 1));
          chk("idle_after_done", 32'({busy, o_tvalid}), 32'h0);
          exp_pkts++;
          expect_done = 1'b0;
        end
        if (prev_stall && o_tvalid) begin
          chk("stall_tdata_hold", o_tdata, prev_data);
          chk("stall_tlast_hold", 32'(o_tlast), 32'(prev_last));
        end
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_sample", 32'(o_tvalid), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("sample_tdata", o_tdata, e.data);
            chk("sample_tlast", 32'(o_tlast), 32'(e.last));
            if (cur_len < 256) got[cur_len] = o_tdata;
            cur_len++;
            if (e.last) begin
              last_len = cur_len; cur_len = 0; expect_done = 1'b1;
            end
          end
        end
        prev_stall = o_tvalid && !o_tready;
        prev_data  = o_tdata;
        prev_last  = o_tlast;
      end
    end
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin @(posedge clk); #1; n++; end
    if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'h0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 5000) begin @(posedge clk); #1; n++; end
    if (!done) chk({name, "_done_timeout"}, 32'(done), 32'h1);
  endtask

  task automatic set_inputs(input logic [31:0] w, input int nb, input int spb, input int rech);
    tx_word = w; num_payload_bits = 8'(nb); samps_per_bit = 16'(spb); recharge_len = 15'(rech);
  endtask

  task automatic start_pkt(input string name, input logic [31:0] w, input int nb, input int spb, input int rech);
    wait_idle(name);
    push_pkt(w, nb, spb, rech);
    set_inputs(w, nb, spb, rech);
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk({name, "_accept_busy"}, 32'(busy), 32'h1);
    chk({name, "_accept_valid"}, 32'(o_tvalid), 32'h1);
    set_inputs(~w, 5, 7, 1);  // in-flight packet must ignore these
  endtask

  initial begin
    logic [15:0] hv;
    rst = 1'b1; tx_start = 1'b0; tx_disable = 1'b0;
    set_inputs(32'h0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(o_tvalid), 32'h0);
    chk("rst_tlast", 32'(o_tlast), 32'h0);
    chk("rst_tdata", o_tdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pkt_count", 32'(packet_count), 32'h0);
    rst = 1'b0;

    // Basic packet, ready always high
    start_pkt("t1", 32'hA5, 8, 4, 10);
    wait_done("t1");
    chk("t1_len", 32'(last_len), 32'd106);
    for (int i = 64; i < 68; i++) chk("t1_bit7", got[i], 32'h4000_0000);
    for (int i = 68; i < 72; i++) chk("t1_bit6", got[i], 32'h0);
    chk("t1_pkt_count", 32'(packet_count), 32'd1);

    // Same packet under random backpressure
    rand_ready = 1'b1;
    start_pkt("t2", 32'hA5, 8, 4, 10);
    wait_done("t2");
    rand_ready = 1'b0;
    chk("t2_len", 32'(last_len), 32'd106);

    // Header only, spb 0 treated as 1
    start_pkt("t3", 32'hFFFF_FFFF, 0, 0, 0);
    wait_done("t3");
    chk("t3_len", 32'(last_len), 32'd16);
    for (int i = 0; i < 16; i++) hv[15 - i] = (got[i] == 32'h4000_0000);
    chk("t3_header", 32'(hv), 32'h0000_B38F);

    // Clamp to 32 bits, tx_start held high: one packet then re-accept in the done cycle
    wait_idle("t4");
    push_pkt(32'hDEAD_BEEF, 40, 1, 3);
    push_pkt(32'hDEAD_BEEF, 40, 1, 3);
    set_inputs(32'hDEAD_BEEF, 40, 1, 3);
    tx_start = 1'b1;
    @(posedge clk); #1;
    chk("t4_accept_busy", 32'(busy), 32'h1);
    wait_done("t4a");
    chk("t4a_len", 32'(last_len), 32'd51);
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk("t4_reaccept_busy", 32'(busy), 32'h1);
    wait_done("t4b");
    chk("t4b_len", 32'(last_len), 32'd51);

    // tx_disable blocks acceptance
    wait_idle("t5");
    tx_disable = 1'b1; tx_start = 1'b1;
    set_inputs(32'h1234_5678, 8, 2, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_disabled_busy", 32'(busy), 32'h0);
    end
    tx_start = 1'b0; tx_disable = 1'b0;

    // tx_disable raised mid-packet lets it finish
    start_pkt("t6", 32'h0000_00F0, 8, 2, 4);
    repeat (5) @(posedge clk);
    #1 tx_disable = 1'b1;
    wait_done("t6");
    chk("t6_len", 32'(last_len), 32'd52);
    tx_disable = 1'b0;

    // Reset mid-packet at sample 30
    start_pkt("t7", 32'hFFFF_FFFF, 32, 1, 0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_rst_tvalid", 32'(o_tvalid), 32'h0);
    chk("t7_rst_tlast", 32'(o_tlast), 32'h0);
    chk("t7_rst_busy", 32'(busy), 32'h0);
    chk("t7_rst_done", 32'(done), 32'h0);
    chk("t7_rst_pkt_count", 32'(packet_count), 32'h0);
    exp_q.delete();
    rst = 1'b0;
    start_pkt("t7b", 32'h3, 2, 1, 0);
    wait_done("t7b");
    chk("t7b_len", 32'(last_len), 32'd18);
    chk("t7b_chip0", got[0], 32'h4000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
